// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encoding,
// default parameter values and the slot-index width helper.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   localparam int DEF_PC_W     = 8;
   localparam int DEF_NUM_BP   = 2;
   localparam int DEF_CNT_W    = 16;
   localparam int DEF_RST_HOLD = 4;
   localparam int DEF_AUTO_RUN = 1;

   // A single slot still needs a one-bit index port.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_ctrl_bp_match.sv
// PC breakpoint bank: slot registers, per-slot comparators and a
// lowest-index priority encoder.
module run_ctrl_bp_match #(
   parameter int PC_W   = 8,
   parameter int NUM_BP = 2,
   parameter int ID_W   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [ID_W-1:0] sel,
   input  logic [PC_W-1:0] addr,
   input  logic            valid,
   input  logic [PC_W-1:0] pc,
   output logic            match,
   output logic [ID_W-1:0] id
);

   logic [PC_W-1:0]   slot_addr [NUM_BP];
   logic [NUM_BP-1:0] slot_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= '0;
         for (int i = 0; i < NUM_BP; i++) slot_addr[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (sel == ID_W'(i)) begin
               slot_valid[i] <= valid;
               slot_addr[i]  <= addr;
            end
         end
      end
   end

   // Scan from the top down so the lowest matching slot is the last one written.
   always_comb begin
      match = 1'b0;
      id    = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (slot_valid[i] && (slot_addr[i] == pc)) begin
            match = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: owns the core's commit enable and provides reset hold,
// run/halt/step, PC breakpoints and a saturating retired-instruction counter.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter  int PC_W     = DEF_PC_W,
   parameter  int NUM_BP   = DEF_NUM_BP,
   parameter  int CNT_W    = DEF_CNT_W,
   parameter  int RST_HOLD = DEF_RST_HOLD,
   parameter  int AUTO_RUN = DEF_AUTO_RUN,
   localparam int ID_W     = id_width(NUM_BP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_run,
   input  logic             cmd_halt,
   input  logic             cmd_step,
   input  logic [7:0]       step_n,
   input  logic             bp_we,
   input  logic [ID_W-1:0]  bp_sel,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_valid,
   input  logic [PC_W-1:0]  pc,
   output logic             cpu_en,
   output logic             halted,
   output logic             bp_hit,
   output logic [ID_W-1:0]  bp_id,
   output logic [CNT_W-1:0] retired
);

   localparam int HOLD_W = $clog2(RST_HOLD + 1);

   state_t            state, state_nx;
   logic [HOLD_W-1:0] hold_cnt;
   logic [7:0]        remaining, remaining_nx;
   logic              skip, skip_nx;
   logic              trap;
   logic              match;
   logic [ID_W-1:0]   match_id;

   run_ctrl_bp_match #(
      .PC_W   (PC_W),
      .NUM_BP (NUM_BP),
      .ID_W   (ID_W)
   ) u_bp_match (
      .clk   (clk),
      .rst   (rst),
      .we    (bp_we),
      .sel   (bp_sel),
      .addr  (bp_addr),
      .valid (bp_valid),
      .pc    (pc),
      .match (match),
      .id    (match_id)
   );

   // skip suppresses the match on the first cycle after a resume from HALT.
   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      skip_nx      = skip;
      trap         = 1'b0;
      cpu_en       = 1'b0;
      case (state)
         ST_INIT: begin
            if (hold_cnt == HOLD_W'(RST_HOLD - 1))
               state_nx = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
         end
         ST_HALT: begin
            if (cmd_step) begin
               state_nx     = ST_STEP;
               remaining_nx = (step_n == 8'd0) ? 8'd1 : step_n;
               skip_nx      = 1'b1;
            end else if (cmd_run) begin
               state_nx = ST_RUN;
               skip_nx  = 1'b1;
            end
         end
         ST_RUN: begin
            skip_nx = 1'b0;
            trap    = match && !skip;
            cpu_en  = !trap;
            if (trap || cmd_halt) state_nx = ST_HALT;
         end
         ST_STEP: begin
            skip_nx = 1'b0;
            trap    = match && !skip;
            cpu_en  = !trap;
            if (trap || cmd_halt || (remaining == 8'd1)) begin
               state_nx     = ST_HALT;
               remaining_nx = 8'd0;
            end else begin
               remaining_nx = remaining - 8'd1;
            end
         end
         default: state_nx = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         hold_cnt  <= '0;
         remaining <= 8'd0;
         skip      <= 1'b0;
         bp_hit    <= 1'b0;
         bp_id     <= '0;
         retired   <= '0;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         skip      <= skip_nx;
         bp_hit    <= trap;
         if (state == ST_INIT) hold_cnt <= hold_cnt + HOLD_W'(1);
         if (trap) bp_id <= match_id;
         if (cpu_en && (retired != '1)) retired <= retired + CNT_W'(1);
      end
   end

   assign halted = (state == ST_HALT);

endmodule
